// File: rtl/imem_if.sv
// Fetch and boot-load bus between the CPU fetch port and the instruction-memory responder.
interface imem_if #(
    parameter int unsigned nbit = 32
);
    logic [nbit-1:0] address;
    logic            req;
    logic            req_ready;
    logic [nbit-1:0] in_Imem;
    logic            rvalid;
    logic            fetch_err;
    logic            ld_valid;
    logic [nbit-1:0] ld_addr;
    logic [nbit-1:0] ld_data;
    logic            ld_ready;
    logic            busy;

    modport master (
        output address, req, ld_valid, ld_addr, ld_data,
        input  req_ready, in_Imem, rvalid, fetch_err, ld_ready, busy
    );

    modport slave (
        input  address, req, ld_valid, ld_addr, ld_data,
        output req_ready, in_Imem, rvalid, fetch_err, ld_ready, busy
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: returns the fetched word a fixed LATENCY cycles after acceptance,
// with a boot-load write port that shares the idle slot.
module imem_responder #(
    parameter int unsigned     nbit       = 32,
    parameter int unsigned     DEPTH_LOG2 = 8,
    parameter int unsigned     LATENCY    = 2,
    parameter logic [nbit-1:0] NOP_WORD   = nbit'(32'h00000013)
) (
    input logic   clk,
    input logic   reset_n,
    imem_if.slave bus
);
    localparam int unsigned Depth   = 2 ** DEPTH_LOG2;
    localparam int unsigned IdxMsb  = DEPTH_LOG2 + 1;
    localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic [nbit-1:0] addr_q;
    logic [nbit-1:0] in_imem_q;
    logic            rvalid_q;
    logic            err_q;
    logic            busy_q;

    logic [nbit-1:0] mem [Depth];

    logic [nbit-1:0] resp_addr;
    logic            resp_ok;
    logic [nbit-1:0] resp_word;
    logic            accept;
    logic            ld_write;

    function automatic logic addr_ok(input logic [nbit-1:0] a);
        return (a[1:0] == 2'b00) && (a[nbit-1:DEPTH_LOG2+2] == '0);
    endfunction

    // The response source is the latched address after WAIT, or the live one when LATENCY is 1.
    always_comb begin
        resp_addr = (state_q == StWait) ? addr_q : bus.address;
        resp_ok   = addr_ok(resp_addr);
        resp_word = resp_ok ? mem[resp_addr[IdxMsb:2]] : NOP_WORD;
        accept    = ((state_q == StIdle) && !bus.ld_valid && bus.req) ||
                    ((state_q == StResp) && bus.req);
        ld_write  = (state_q == StIdle) && bus.ld_valid && addr_ok(bus.ld_addr);
    end

    assign bus.req_ready = ((state_q == StIdle) && !bus.ld_valid) || (state_q == StResp);
    assign bus.ld_ready  = (state_q == StIdle);
    assign bus.in_Imem   = in_imem_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.fetch_err = err_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            in_imem_q <= NOP_WORD;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            unique case (state_q)
                StIdle, StResp: begin
                    if (accept) begin
                        addr_q <= bus.address;
                        cnt_q  <= CntLoad;
                        if (LATENCY == 1) begin
                            state_q   <= StResp;
                            rvalid_q  <= 1'b1;
                            err_q     <= !resp_ok;
                            in_imem_q <= resp_word;
                        end else begin
                            state_q <= StWait;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (cnt_q <= 4'd1) begin
                        state_q   <= StResp;
                        rvalid_q  <= 1'b1;
                        err_q     <= !resp_ok;
                        in_imem_q <= resp_word;
                    end else begin
                        cnt_q  <= cnt_q - 4'd1;
                        busy_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Memory contents survive reset; misaligned or out-of-range loads are dropped here.
    always_ff @(posedge clk) begin
        if (ld_write) begin
            mem[bus.ld_addr[IdxMsb:2]] <= bus.ld_data;
        end
    end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory-side end of the CPU fetch interface.
- Accepts a fetch address from the CPU core and returns the 32-bit instruction word after a fixed, parameterised latency, using a req/ready and rvalid handshake.
- Also provides a boot-load write port that fills the memory before or between fetches.
- Sits between the core's fetch port and the on-chip instruction store.

Parameters:
- nbit, 32, data/address width.
- DEPTH_LOG2, 8, log2 of memory depth in words (default 256 words, 1 KiB).
- LATENCY, 2, cycles from fetch acceptance to rvalid; legal range 1..15.
- NOP_WORD, 32'h00000013, word returned on error (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- address  input  nbit  fetch byte address from the CPU.
- req  input  1  fetch request; address is valid while req is high.
- req_ready  output  1  fetch accepted on a cycle where req && req_ready.
- in_Imem  output  nbit  instruction word to the CPU; valid when rvalid is high.
- rvalid  output  1  one-cycle pulse marking in_Imem valid.
- fetch_err  output  1  qualifies rvalid: the fetch was misaligned or out of range.
- ld_valid  input  1  boot-load write request.
- ld_addr  input  nbit  boot-load byte address.
- ld_data  input  nbit  boot-load word.
- ld_ready  output  1  load accepted on a cycle where ld_valid && ld_ready.
- busy  output  1  a fetch is pending (state WAIT).

Behaviour:
- Reset, asynchronous with reset_n low, forces:
  - state to IDLE, latency counter to 0.
  - in_Imem = NOP_WORD; rvalid = 0; fetch_err = 0; busy = 0.
  - req_ready = 1; ld_ready = 1.
  - Memory array contents are not reset.
- Word index is address[DEPTH_LOG2+1:2].
- Error fetch: address[1:0] != 0, or address >= 4*2^DEPTH_LOG2.
  - Responds in_Imem = NOP_WORD with fetch_err = 1 and the same latency.
  - No memory read is performed.
- Error load: misaligned or out-of-range ld_addr.
  - Accepted (handshake completes) and silently dropped; no write occurs.
- States:
  - IDLE: req_ready = !ld_valid; ld_ready = 1.
    - If ld_valid: write ld_data at the clock edge and stay in IDLE. Load has priority over a same-cycle req; that req is not accepted.
    - Else if req: latch address, set counter = LATENCY-1, then go to WAIT, or RESP if LATENCY == 1.
  - WAIT: busy = 1; req_ready = 0; ld_ready = 0.
    - Counter decrements each cycle; at counter == 1, go to RESP.
  - RESP: rvalid = 1, with in_Imem/fetch_err for the latched address. Memory is read on the edge entering RESP.
    - ld_ready = 0; req_ready = 1, so a back-to-back fetch may be accepted.
    - If req: latch the new address and reload the counter as in IDLE. The next rvalid arrives exactly LATENCY cycles later.
    - Else: return to IDLE.
- Latency: fetch accepted at edge T gives rvalid high in the cycle after edge T+LATENCY-1, i.e. exactly LATENCY cycles after acceptance. Maximum throughput is one fetch per LATENCY cycles.
- Outside RESP:
  - in_Imem holds its last value; rvalid = 0; fetch_err = 0.
- Address handling:
  - address is sampled only at acceptance; changes afterwards are ignored.
  - req deasserted in WAIT has no effect.
- Read-after-write: a load accepted at edge T followed by a fetch of the same word accepted at edge T+1 returns the newly written data.
- Reset mid-operation: a pending fetch is discarded, no rvalid follows, and the state returns to IDLE. A load write in progress on the reset edge is not guaranteed.

Test Plan:
- Reset then idle → in_Imem=0x00000013, rvalid=0, req_ready=1, ld_ready=1, busy=0.
- Load 0x00500093 at 0x0 and 0x00A00113 at 0x4. Fetch 0x0 with LATENCY=2 → rvalid exactly 2 cycles after acceptance, in_Imem=0x00500093, fetch_err=0, busy=1 for 1 cycle.
- Back-to-back fetch 0x0, 0x4, with req held and address changed in the RESP cycle → rvalid pulses 2 cycles apart, returning 0x00500093 then 0x00A00113.
- Fetch 0x2 (misaligned) and 0x400 (out of range, DEPTH_LOG2=8) → in_Imem=0x00000013, fetch_err=1 on rvalid. A load to 0x402 completes its handshake with memory unchanged.
- ld_valid and req asserted together in IDLE → load accepted, req_ready=0 that cycle. The fetch of the same address is accepted next cycle and returns the new word.
- reset_n pulsed low in WAIT → busy=0 and no rvalid. A subsequent fetch of 0x4 returns 0x00A00113. Repeat with LATENCY=1: rvalid in the cycle after acceptance.
